// File: rtl/ntt_sched_pkg.sv
// rtl/ntt_sched_pkg.sv - shared constants and FSM encoding for the NTT job scheduler
package ntt_sched_pkg;
  localparam int DEPTH_DEF   = 4;
  localparam int RD_LAT_DEF  = 3;
  localparam int CALC_TO_DEF = 1023;
  localparam int PAIR_W      = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    CALC    = 3'd3,
    DRAIN   = 3'd4,
    RELEASE = 3'd5
  } state_e;
endpackage

// File: rtl/ntt_sched_if.sv
// rtl/ntt_sched_if.sv - requester and core-side signal bundle of the NTT job scheduler
interface ntt_sched_if import ntt_sched_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF
) ();
  logic [1:0]            req;
  logic [1:0]            gnt;
  logic [1:0]            in_valid;
  logic [2*PAIR_W-1:0]   in_data;
  logic [1:0]            in_ready;
  logic                  out_valid;
  logic [PAIR_W-1:0]     out_data;
  logic [DEPTH-1:0]      out_index;
  logic                  busy;
  logic                  err;
  logic                  ntt_set;
  logic                  ntt_rst;
  logic                  ntt_readin;
  logic                  ntt_readout;
  logic                  ntt_cal_en;
  logic [PAIR_W/2-1:0]   ntt_din_1;
  logic [PAIR_W/2-1:0]   ntt_din_2;
  logic [DEPTH-1:0]      ntt_in_index;
  logic                  ntt_done;
  logic [PAIR_W/2-1:0]   ntt_dout_1;
  logic [PAIR_W/2-1:0]   ntt_dout_2;

  modport master (
    input  req, in_valid, in_data, ntt_done, ntt_dout_1, ntt_dout_2,
    output gnt, in_ready, out_valid, out_data, out_index, busy, err,
           ntt_set, ntt_rst, ntt_readin, ntt_readout, ntt_cal_en,
           ntt_din_1, ntt_din_2, ntt_in_index
  );

  modport slave (
    output req, in_valid, in_data, ntt_done, ntt_dout_1, ntt_dout_2,
    input  gnt, in_ready, out_valid, out_data, out_index, busy, err,
           ntt_set, ntt_rst, ntt_readin, ntt_readout, ntt_cal_en,
           ntt_din_1, ntt_din_2, ntt_in_index
  );
endinterface

// File: rtl/ntt_rr_arb.sv
// rtl/ntt_rr_arb.sv - two-way round-robin arbiter; on a tie the requester not granted last wins
module ntt_rr_arb (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: rtl/ntt_sched.sv
// rtl/ntt_sched.sv - arbitrates two requesters onto one NTT core and sequences load/calc/drain
module ntt_sched import ntt_sched_pkg::*; #(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int RD_LAT  = RD_LAT_DEF,
  parameter int CALC_TO = CALC_TO_DEF
) (
  input  logic        clk,
  input  logic        reset,
  ntt_sched_if.master bus
);
  localparam int HALF = 1 << (DEPTH - 1);
  localparam int DW   = $clog2(RD_LAT + HALF + 1);
  localparam int CW   = $clog2(CALC_TO + 1);
  localparam int HW   = PAIR_W / 2;

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [DEPTH-1:0]  cnt_q, cnt_d;
  logic [DEPTH-1:0]  oidx_q, oidx_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [CW-1:0]     calc_q, calc_d;
  logic              lowseen_q, lowseen_d;
  logic              err_q, err_d;
  logic              rst_hold_q;
  logic [1:0]        arb_gnt;
  logic [PAIR_W-1:0] sel_pair;
  logic              accept;
  logic              drain_out;

  ntt_rr_arb u_arb (
    .req_i  (bus.req),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  // Only the granted lane is ever muxed towards the core.
  assign sel_pair  = gnt_q[1] ? bus.in_data[2*PAIR_W-1:PAIR_W] : bus.in_data[PAIR_W-1:0];
  assign accept    = (state_q == LOAD) && |(bus.in_valid & gnt_q);
  assign drain_out = (state_q == DRAIN) && (drain_q >= DW'(RD_LAT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      oidx_q     <= '0;
      drain_q    <= '0;
      calc_q     <= '0;
      lowseen_q  <= 1'b0;
      err_q      <= 1'b0;
      rst_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      oidx_q     <= oidx_d;
      drain_q    <= drain_d;
      calc_q     <= calc_d;
      lowseen_q  <= lowseen_d;
      err_q      <= err_d;
      rst_hold_q <= 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    oidx_d    = oidx_q;
    drain_d   = drain_q;
    calc_d    = calc_q;
    lowseen_d = lowseen_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = arb_gnt;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DEPTH'(HALF - 1)) state_d = START;
        end
      end
      START: state_d = CALC;
      CALC: begin
        // A stale high ntt_done from a previous job must not end this one.
        calc_d = calc_q + 1'b1;
        if (!bus.ntt_done) lowseen_d = 1'b1;
        if (lowseen_q && bus.ntt_done) begin
          state_d = DRAIN;
        end else if (calc_q == CW'(CALC_TO - 1)) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_out) oidx_d = oidx_q + DEPTH'(2);
        if (drain_q == DW'(RD_LAT + HALF - 1)) state_d = RELEASE;
      end
      RELEASE: begin
        gnt_d     = '0;
        last_d    = gnt_q[1];
        cnt_d     = '0;
        oidx_d    = '0;
        drain_d   = '0;
        calc_d    = '0;
        lowseen_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt          = gnt_q;
    bus.in_ready     = (state_q == LOAD) ? gnt_q : 2'b00;
    bus.busy         = (state_q != IDLE);
    bus.err          = err_q;
    bus.ntt_set      = (state_q != IDLE) && (state_q != RELEASE);
    bus.ntt_rst      = rst_hold_q || (state_q == RELEASE);
    bus.ntt_readin   = (state_q == LOAD);
    bus.ntt_readout  = (state_q == DRAIN);
    bus.ntt_cal_en   = (state_q == START);
    bus.ntt_din_1    = '0;
    bus.ntt_din_2    = '0;
    bus.ntt_in_index = '0;
    if (state_q == LOAD) begin
      bus.ntt_din_1    = sel_pair[PAIR_W-1:HW];
      bus.ntt_din_2    = sel_pair[HW-1:0];
      bus.ntt_in_index = cnt_q << 1;
    end
    bus.out_valid = drain_out;
    bus.out_data  = drain_out ? {bus.ntt_dout_1, bus.ntt_dout_2} : '0;
    bus.out_index = drain_out ? oidx_q : '0;
  end
endmodule

// File: tb/tb_ntt_sched.sv
// tb/tb_ntt_sched.sv - directed scoreboard bench for ntt_sched with a behavioural NTT core stub
module tb_ntt_sched;
  localparam int RD_LAT  = 3;
  localparam int CALC_TO = 40;

  typedef logic [15:0] vec_t [16];
  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
  } sb_t;

  logic clk;
  logic rst;
  bit   stuck;
  int   n_pass, n_total;
  int   acc_cnt, cal_cnt, out_cnt, rst_cnt, calc_cycles, acc_in_job;
  int   snap_acc, snap_cal, snap_out, snap_rst;
  logic [15:0] cur_odd, cur_even;
  sb_t  sb[$];
  sb_t  e;

  vec_t mem, res;
  logic done_q;
  int   tmr, rcnt, oi;
  logic [15:0] dout1, dout2;

  ntt_sched_if #(.DEPTH(4)) bus ();

  ntt_sched #(.DEPTH(4), .RD_LAT(RD_LAT), .CALC_TO(CALC_TO)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cyclic NTT over Z_257 with an order-16 root of unity (3^16).
  function automatic logic [15:0] ntt_coef(input vec_t a, input int k);
    int acc, w, wk, g;
    g = 1;
    for (int i = 0; i < 16; i++) g = (g * 3) % 257;
    wk = 1;
    for (int i = 0; i < k; i++) wk = (wk * g) % 257;
    acc = 0;
    w = 1;
    for (int j = 0; j < 16; j++) begin
      acc = (acc + (int'(a[j]) % 257) * w) % 257;
      w = (w * wk) % 257;
    end
    return 16'(acc);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b1;
      tmr    <= 0;
      rcnt   <= 0;
    end else begin
      if (bus.ntt_readin) begin
        mem[int'(bus.ntt_in_index)]     <= bus.ntt_din_2;
        mem[int'(bus.ntt_in_index) + 1] <= bus.ntt_din_1;
      end
      if (bus.ntt_cal_en) begin
        for (int k = 0; k < 16; k++) res[k] <= ntt_coef(mem, k);
        done_q <= 1'b0;
        tmr    <= 4;
      end else if (tmr != 0) begin
        tmr <= tmr - 1;
        if (tmr == 1) done_q <= 1'b1;
      end
      rcnt <= bus.ntt_readout ? rcnt + 1 : 0;
    end
  end

  always_comb begin
    oi = 2 * (rcnt - RD_LAT);
    dout1 = 16'hdead;
    dout2 = 16'hdead;
    if (rcnt >= RD_LAT && oi < 15) begin
      dout1 = res[oi + 1];
      dout2 = res[oi];
    end
  end

  assign bus.ntt_done   = stuck ? 1'b1 : done_q;
  assign bus.ntt_dout_1 = dout1;
  assign bus.ntt_dout_2 = dout2;

  always @(negedge clk) begin
    if (!rst) begin
      check("gnt_overlap", 64'(bus.gnt == 2'b11), 0);
      check("ready_leak", 64'(bus.in_ready & ~bus.gnt), 0);
      if (!bus.busy) acc_in_job = 0;
      if (bus.ntt_readin) check("in_index", bus.ntt_in_index, 64'(2 * acc_in_job));
      if (bus.ntt_readin && |(bus.in_valid & bus.in_ready)) begin
        check("din_1", bus.ntt_din_1, cur_odd);
        check("din_2", bus.ntt_din_2, cur_even);
        acc_cnt++;
        acc_in_job++;
      end
      if (bus.ntt_cal_en) begin
        cal_cnt++;
        calc_cycles = 0;
      end else if (bus.ntt_set && !bus.ntt_readin && !bus.ntt_readout) begin
        calc_cycles++;
      end
      if (bus.ntt_rst && bus.busy) rst_cnt++;
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out", bus.out_valid, 0);
        end else begin
          e = sb.pop_front();
          check("out_index", bus.out_index, e.idx);
          check("out_data", bus.out_data, e.data);
        end
        out_cnt++;
      end
    end
  end

  task automatic load_job(input logic [1:0] reqv, input logic [1:0] exp_gnt, input int base,
                          input bit toggle, input bit drop_in_load, input bit expect_out);
    int r, k;
    vec_t a;
    snap_acc = acc_cnt;
    snap_cal = cal_cnt;
    snap_out = out_cnt;
    snap_rst = rst_cnt;
    bus.req = reqv;
    k = 0;
    while (bus.gnt == 2'b00 && k < 20) begin step(); k++; end
    check("grant", bus.gnt, exp_gnt);
    r = exp_gnt[1] ? 1 : 0;
    for (int j = 0; j < 16; j++) a[j] = 16'(base + j);
    if (expect_out)
      for (int p = 0; p < 8; p++)
        sb.push_back('{idx: 4'(2 * p), data: {ntt_coef(a, 2 * p + 1), ntt_coef(a, 2 * p)}});
    if (drop_in_load) bus.req = 2'b00;
    bus.in_valid[1 - r] = 1'b1;
    for (int p = 0; p < 8; p++) begin
      bus.in_data[32 * (1 - r) +: 32] = 32'hbad0_0000 | 32'(p);
      if (toggle) begin
        bus.in_valid[r] = 1'b0;
        bus.in_data[32 * r +: 32] = 32'hdead_beef;
        step();
      end
      cur_odd  = a[2 * p + 1];
      cur_even = a[2 * p];
      bus.in_valid[r] = 1'b1;
      bus.in_data[32 * r +: 32] = {cur_odd, cur_even};
      k = 0;
      while (!bus.in_ready[r] && k < 20) begin step(); k++; end
      check("ready_wait", bus.in_ready[r], 1);
      step();
    end
    bus.in_valid = 2'b00;
  endtask

  task automatic finish_job(input int exp_outs);
    int k;
    k = 0;
    while (bus.busy && k < CALC_TO + 60) begin step(); k++; end
    check("job_end", bus.busy, 0);
    check("accepts", 64'(acc_cnt - snap_acc), 8);
    check("cal_en_pulses", 64'(cal_cnt - snap_cal), 1);
    check("out_pairs", 64'(out_cnt - snap_out), 64'(exp_outs));
    check("rst_pulses", 64'(rst_cnt - snap_rst), 1);
    check("sb_drained", 64'(sb.size()), 0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    stuck = 1'b0;
    bus.req = 2'b00;
    bus.in_valid = 2'b00;
    bus.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_index", bus.out_index, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    check("rst_ntt_rst", bus.ntt_rst, 1);
    check("rst_core_ctl", {bus.ntt_set, bus.ntt_readin, bus.ntt_readout, bus.ntt_cal_en}, 0);
    check("rst_core_data", {bus.ntt_din_1, bus.ntt_din_2, bus.ntt_in_index}, 0);
    rst = 1'b0;

    load_job(2'b01, 2'b01, 0, 1'b0, 1'b1, 1'b1);
    finish_job(8);

    load_job(2'b10, 2'b10, 50, 1'b1, 1'b1, 1'b1);
    finish_job(8);

    load_job(2'b11, 2'b01, 100, 1'b0, 1'b0, 1'b1);
    finish_job(8);
    load_job(2'b11, 2'b10, 150, 1'b0, 1'b1, 1'b1);
    finish_job(8);

    load_job(2'b01, 2'b01, 200, 1'b0, 1'b0, 1'b1);
    step();
    step();
    check("drop_in_calc", {bus.ntt_set, bus.ntt_readin, bus.ntt_readout, bus.ntt_cal_en}, 4'b1000);
    bus.req = 2'b00;
    finish_job(8);

    check("err_before_to", bus.err, 0);
    stuck = 1'b1;
    load_job(2'b10, 2'b10, 250, 1'b0, 1'b1, 1'b0);
    finish_job(0);
    check("to_calc_cycles", 64'(calc_cycles), CALC_TO);
    check("to_err", bus.err, 1);
    stuck = 1'b0;

    load_job(2'b01, 2'b01, 300, 1'b0, 1'b1, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 60) begin step(); k++; end
    check("drain_reached", bus.out_valid, 1);
    step();
    check("err_sticky", bus.err, 1);
    rst = 1'b1;
    step();
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_gnt", bus.gnt, 0);
    check("mid_rst_ntt_rst", bus.ntt_rst, 1);
    check("mid_rst_err", bus.err, 0);
    rst = 1'b0;
    sb.delete();
    snap_out = out_cnt;
    repeat (10) step();
    check("post_rst_no_out", 64'(out_cnt - snap_out), 0);
    check("post_rst_idle", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ntt_sched.md
NTT_SCHED -- requirements
Module: ntt_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning log2 of the coefficient count N = 2^DEPTH.
REQ-002 SHALL have parameter RD_LAT, default 3, meaning cycles from the first ntt_readout assertion to the first valid core output pair.
REQ-003 SHALL have parameter CALC_TO, default 1023, meaning the watchdog limit in cycles for the CALC state.
REQ-004 SHALL provide: clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL provide: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL provide: req  in  2  per-requester transform request (level).
REQ-007 SHALL provide: gnt  out  2  one-hot grant, held for the whole job.
REQ-008 SHALL provide: in_valid  in  2  per-requester input-pair valid.
REQ-009 SHALL provide: in_data  in  64  per-requester input pair; requester r uses bits [32r+31:32r] = {odd coeff, even coeff}.
REQ-010 SHALL provide: in_ready  out  2  per-requester input-pair ready.
REQ-011 SHALL provide: out_valid, out_data (32), out_index (DEPTH), all outputs: result pair {i+1, i}, with out_index = i, routed to the granted requester.
REQ-012 SHALL provide: busy  out  1  and  err  out  1  (sticky watchdog flag).
REQ-013 SHALL provide the core-side outputs ntt_set, ntt_rst, ntt_readin, ntt_readout, ntt_cal_en (1 bit each), ntt_din_1 and ntt_din_2 (16 bits each) and ntt_in_index (DEPTH bits).
REQ-014 SHALL provide the core-side inputs ntt_done (1 bit) and ntt_dout_1 and ntt_dout_2 (16 bits each).

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, START, CALC, DRAIN and RELEASE.
REQ-016 IDLE: if any req bit is set, SHALL grant round-robin, preferring the requester other than the last-granted one, then go to LOAD; tie at first job after reset goes to requester 0.
REQ-017 LOAD: in_ready[g] = 1 and ntt_readin = 1; a pair is accepted on cycle where in_valid[g] && in_ready[g]; din_1 = odd, din_2 = even, in_index = 2*count; after N/2 pairs go to START.
REQ-018 in_ready of a non-granted requester SHALL be 0 at all times.
REQ-019 START: ntt_cal_en = 1 for exactly one cycle, with readin = 0 and readout = 0; then go to CALC.
REQ-020 CALC: SHALL wait until ntt_done has been observed low and subsequently high, then go to DRAIN.
REQ-021 CALC watchdog: if the cycles spent in CALC reach CALC_TO, SHALL set err and go to RELEASE with no output.
REQ-022 DRAIN: ntt_readout = 1 for RD_LAT + N/2 cycles; out_valid = 1 on the final N/2 of them.
REQ-023 DRAIN output: out_data = {ntt_dout_1, ntt_dout_2} and out_index = 0, 2, 4, ... from an internal counter, not from the core.
REQ-024 DRAIN SHALL NOT apply backpressure: the consumer must accept one pair per cycle.
REQ-025 RELEASE: ntt_rst = 1 for one cycle, gnt cleared, last-grant updated; then go to IDLE.
REQ-026 ntt_set SHALL be 1 in every state except IDLE and RELEASE.
REQ-027 busy SHALL be 1 whenever the state is not IDLE.
REQ-028 Dropping req mid-job SHALL have no effect; a job always completes or times out.
REQ-029 Requester-0 input data SHALL never reach the core while requester 1 is granted, and vice versa.
REQ-030 err SHALL be cleared only by reset.

Reset
REQ-031 On reset: state = IDLE; gnt = 0; in_ready = 0; out_valid = 0; out_data = 0; out_index = 0; busy = 0; err = 0; last-grant = 1; all counters = 0.
REQ-032 On reset, core-side outputs SHALL be 0 except ntt_rst, which is 1.
REQ-033 Reset asserted in any state SHALL abort the job on the next clock edge, with no partial output.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the default DEPTH, RD_LAT and CALC_TO, and the pair-width constant (32).
REQ-035 Round-robin arbitration SHALL be a sub-module, ntt_rr_arb (2 requesters, last-grant input, one-hot output).

Verification
REQ-036 Bench SHALL cover: req = 01, pairs 0..7 with coeff i = i (DEPTH 4) -> gnt = 01; 8 accepted pairs; one cal_en pulse; 8 out_valid cycles with out_index 0..14 matching a golden NTT model.
REQ-037 Bench SHALL cover: req = 11 held, two jobs -> grants 01 then 10; ntt_rst pulse between jobs; no overlap of gnt.
REQ-038 Bench SHALL cover: in_valid toggling 1/0 during LOAD -> exactly 8 acceptances; ntt_in_index increments only on accept.
REQ-039 Bench SHALL cover: core stub holding ntt_done = 1 forever -> err = 1 after CALC_TO cycles, RELEASE, no out_valid.
REQ-040 Bench SHALL cover: reset pulsed mid-DRAIN -> next cycle state IDLE, out_valid = 0, gnt = 0, ntt_rst = 1.
REQ-041 Bench SHALL cover: req[0] dropped during CALC -> job completes with all 8 output pairs.
